// File: rtl/vip_sobel_gradient_dir.sv
// Sobel gradient magnitude/direction with per-frame configuration shadowing
// and per-frame edge-pixel statistics. Four-stage pipeline, free-running.
module vip_sobel_gradient_dir #(
  parameter int unsigned  DATA_W        = 8,
  parameter int unsigned  DEF_THRESHOLD = 250,
  parameter int unsigned  DEF_MODE      = 0,
  parameter int unsigned  CNT_W         = 20,
  localparam int unsigned MAG_W         = DATA_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] matrix_p11,
  input  logic [DATA_W-1:0] matrix_p12,
  input  logic [DATA_W-1:0] matrix_p13,
  input  logic [DATA_W-1:0] matrix_p21,
  input  logic [DATA_W-1:0] matrix_p22,
  input  logic [DATA_W-1:0] matrix_p23,
  input  logic [DATA_W-1:0] matrix_p31,
  input  logic [DATA_W-1:0] matrix_p32,
  input  logic [DATA_W-1:0] matrix_p33,
  input  logic [MAG_W-1:0]  cfg_threshold,
  input  logic              cfg_mode,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [MAG_W-1:0]  post_grad_mag,
  output logic [1:0]        post_grad_dir,
  output logic              post_edge_bit,
  output logic [CNT_W-1:0]  frame_edge_count,
  output logic              frame_stat_valid
);

  // Weighted sums span 4*(2^DATA_W-1); products for the direction test need
  // room for |g| * 618 (< 2^10).
  localparam int unsigned SUM_W  = DATA_W + 2;
  localparam int unsigned PROD_W = SUM_W + 10;

  localparam logic [PROD_W-1:0] K_SHALLOW    = PROD_W'(106);
  localparam logic [PROD_W-1:0] K_STEEP      = PROD_W'(618);
  localparam logic [MAG_W-1:0]  THR_RESET    = MAG_W'(DEF_THRESHOLD);
  localparam logic              MODE_RESET   = (DEF_MODE != 0);

  // 2-bit direction codes
  typedef enum logic [1:0] {
    DIR_HORZ = 2'd0,
    DIR_DIAG = 2'd1,
    DIR_VERT = 2'd2,
    DIR_ANTI = 2'd3
  } dir_e;

  // Sync delay lines (index 3 drives the outputs)
  logic [3:0] vs_q, hr_q, ce_q;

  // Configuration shadows
  logic [MAG_W-1:0] thr_q, thr_d;
  logic             mode_q, mode_d;
  logic             shadow_load;

  // Stage 1
  logic [SUM_W-1:0] s1_colr_d, s1_coll_d, s1_rowt_d, s1_rowb_d;
  logic [SUM_W-1:0] s1_colr_q, s1_coll_q, s1_rowt_q, s1_rowb_q;

  // Stage 2
  logic [SUM_W-1:0] s2_ax_d, s2_ay_d, s2_ax_q, s2_ay_q;
  logic             s2_sx_d, s2_sy_d, s2_sx_q, s2_sy_q;

  // Stage 3
  logic [PROD_W-1:0] ax_w, ay256, lim_lo, lim_hi;
  logic [SUM_W-1:0]  g_max, g_min;
  logic [MAG_W-1:0]  s3_mag_d, s3_mag_q;
  dir_e              s3_dir_d, s3_dir_q;

  // Stage 4 / outputs
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [1:0]       dir_q, dir_d;
  logic             edge_q, edge_d;

  // Frame statistics
  logic             post_vs_prev_q;
  logic             vs_rise, cnt_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [CNT_W-1:0] fec_q, fec_d;
  logic             stat_q, stat_d;

  // Sync signals ride alongside the data through all four stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= '0;
      hr_q <= '0;
      ce_q <= '0;
    end else begin
      vs_q <= {vs_q[2:0], per_frame_vsync};
      hr_q <= {hr_q[2:0], per_frame_href};
      ce_q <= {ce_q[2:0], per_frame_clken};
    end
  end

  // Shadows reload when the 2-clk-delayed vsync rises, before any pixel of the frame
  always_comb begin
    shadow_load = vs_q[1] & ~vs_q[2];
    thr_d       = thr_q;
    mode_d      = mode_q;
    if (shadow_load) begin
      thr_d  = cfg_threshold;
      mode_d = cfg_mode;
    end
  end

  // Shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q  <= THR_RESET;
      mode_q <= MODE_RESET;
    end else begin
      thr_q  <= thr_d;
      mode_q <= mode_d;
    end
  end

  // S1: row and column weighted sums
  always_comb begin
    s1_colr_d = {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
    s1_coll_d = {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
    s1_rowt_d = {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};
    s1_rowb_d = {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
  end

  // S2: absolute gradients and signs; subtracting the smaller sum avoids signed math
  always_comb begin
    if (s1_colr_q >= s1_coll_q) begin
      s2_ax_d = s1_colr_q - s1_coll_q;
      s2_sx_d = 1'b0;
    end else begin
      s2_ax_d = s1_coll_q - s1_colr_q;
      s2_sx_d = 1'b1;
    end
    if (s1_rowt_q >= s1_rowb_q) begin
      s2_ay_d = s1_rowt_q - s1_rowb_q;
      s2_sy_d = 1'b0;
    end else begin
      s2_ay_d = s1_rowb_q - s1_rowt_q;
      s2_sy_d = 1'b1;
    end
  end

  // S3: magnitude by mode and quantised direction (tan 22.5 ~ 106/256, tan 67.5 ~ 618/256)
  always_comb begin
    ax_w   = {10'd0, s2_ax_q};
    ay256  = {2'b00, s2_ay_q, 8'd0};
    lim_lo = ax_w * K_SHALLOW;
    lim_hi = ax_w * K_STEEP;
    if (s2_ax_q >= s2_ay_q) begin
      g_max = s2_ax_q;
      g_min = s2_ay_q;
    end else begin
      g_max = s2_ay_q;
      g_min = s2_ax_q;
    end
    if (mode_q)
      s3_mag_d = {1'b0, g_max} + {1'b0, (g_min >> 1)};
    else
      s3_mag_d = {1'b0, s2_ax_q} + {1'b0, s2_ay_q};
    s3_dir_d = DIR_HORZ;
    if (s2_ax_q == '0 && s2_ay_q == '0)
      s3_dir_d = DIR_HORZ;
    else if (ay256 < lim_lo)
      s3_dir_d = DIR_HORZ;
    else if (ay256 > lim_hi)
      s3_dir_d = DIR_VERT;
    else if (s2_sx_q == s2_sy_q)
      s3_dir_d = DIR_DIAG;
    else
      s3_dir_d = DIR_ANTI;
  end

  // S4: threshold compare, outputs blanked outside active line
  always_comb begin
    mag_d  = '0;
    dir_d  = '0;
    edge_d = 1'b0;
    if (hr_q[2]) begin
      mag_d  = s3_mag_q;
      dir_d  = s3_dir_q;
      edge_d = (s3_mag_q >= thr_q);
    end
  end

  // Pipeline data registers S1..S4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_colr_q <= '0;
      s1_coll_q <= '0;
      s1_rowt_q <= '0;
      s1_rowb_q <= '0;
      s2_ax_q   <= '0;
      s2_ay_q   <= '0;
      s2_sx_q   <= 1'b0;
      s2_sy_q   <= 1'b0;
      s3_mag_q  <= '0;
      s3_dir_q  <= DIR_HORZ;
      mag_q     <= '0;
      dir_q     <= '0;
      edge_q    <= 1'b0;
    end else begin
      s1_colr_q <= s1_colr_d;
      s1_coll_q <= s1_coll_d;
      s1_rowt_q <= s1_rowt_d;
      s1_rowb_q <= s1_rowb_d;
      s2_ax_q   <= s2_ax_d;
      s2_ay_q   <= s2_ay_d;
      s2_sx_q   <= s2_sx_d;
      s2_sy_q   <= s2_sy_d;
      s3_mag_q  <= s3_mag_d;
      s3_dir_q  <= s3_dir_d;
      mag_q     <= mag_d;
      dir_q     <= dir_d;
      edge_q    <= edge_d;
    end
  end

  // Frame statistics: a counted pixel coinciding with the vsync rise starts the new frame at 1
  always_comb begin
    vs_rise  = vs_q[3] & ~post_vs_prev_q;
    cnt_inc  = edge_q & ce_q[3];
    cnt_base = vs_rise ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (cnt_inc && cnt_base != '1)
      cnt_d = cnt_base + 1'b1;
    fec_d  = vs_rise ? cnt_q : fec_q;
    stat_d = vs_rise;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vs_prev_q <= 1'b0;
      cnt_q          <= '0;
      fec_q          <= '0;
      stat_q         <= 1'b0;
    end else begin
      post_vs_prev_q <= vs_q[3];
      cnt_q          <= cnt_d;
      fec_q          <= fec_d;
      stat_q         <= stat_d;
    end
  end

  assign post_frame_vsync = vs_q[3];
  assign post_frame_href  = hr_q[3];
  assign post_frame_clken = ce_q[3];
  assign post_grad_mag    = mag_q;
  assign post_grad_dir    = dir_q;
  assign post_edge_bit    = edge_q;
  assign frame_edge_count = fec_q;
  assign frame_stat_valid = stat_q;

endmodule

// File: tb/tb_vip_sobel_gradient_dir.sv
// Self-checking bench: random and directed windows against a plain-arithmetic
// reference model of the Sobel gradient, shadowed config and frame counter.
module tb_vip_sobel_gradient_dir;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MAG_W  = 11;
  localparam int unsigned CNT_W  = 20;
  localparam int          NCYC   = 8192;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vsync, href, clken;
  logic [DATA_W-1:0] pix [9];
  logic [MAG_W-1:0]  cfg_thr;
  logic              cfg_mode;
  logic              o_vs, o_hr, o_ce, o_edge, o_stat;
  logic [MAG_W-1:0]  o_mag;
  logic [1:0]        o_dir;
  logic [CNT_W-1:0]  o_fec;

  always #5 clk = ~clk;

  vip_sobel_gradient_dir #(
    .DATA_W(DATA_W), .DEF_THRESHOLD(250), .DEF_MODE(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .matrix_p11(pix[0]), .matrix_p12(pix[1]), .matrix_p13(pix[2]),
    .matrix_p21(pix[3]), .matrix_p22(pix[4]), .matrix_p23(pix[5]),
    .matrix_p31(pix[6]), .matrix_p32(pix[7]), .matrix_p33(pix[8]),
    .cfg_threshold(cfg_thr), .cfg_mode(cfg_mode),
    .post_frame_vsync(o_vs), .post_frame_href(o_hr), .post_frame_clken(o_ce),
    .post_grad_mag(o_mag), .post_grad_dir(o_dir), .post_edge_bit(o_edge),
    .frame_edge_count(o_fec), .frame_stat_valid(o_stat)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  // Expected output per cycle index (cycle = number of rising edges seen)
  int unsigned e_vs [NCYC];
  int unsigned e_hr [NCYC];
  int unsigned e_ce [NCYC];
  int unsigned e_mag[NCYC];
  int unsigned e_dir[NCYC];
  int unsigned e_edg[NCYC];
  int unsigned e_st [NCYC];
  int unsigned e_cnt[NCYC];

  // Reference model state
  int unsigned m_thr = 250;
  int unsigned m_mode = 0;
  bit          m_prev_vs = 1'b0;
  int unsigned m_run = 0;
  int unsigned m_fec = 0;
  int unsigned pulses = 0;
  int unsigned last_fec = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model of the window captured at edge c; its result appears after edge c+3
  task automatic record(input int c);
    int gx, gy, ax, ay, mx, mn, mag, dir, o;
    bit edg;
    o = c + 3;
    if (o + 1 >= NCYC) return;
    gx = (int'(pix[2]) + 2*int'(pix[5]) + int'(pix[8])) - (int'(pix[0]) + 2*int'(pix[3]) + int'(pix[6]));
    gy = (int'(pix[0]) + 2*int'(pix[1]) + int'(pix[2])) - (int'(pix[6]) + 2*int'(pix[7]) + int'(pix[8]));
    if (vsync && !m_prev_vs) begin
      m_thr  = cfg_thr;
      m_mode = cfg_mode;
      e_st[o+1]  = 1;
      e_cnt[o+1] = m_run;
      m_run = 0;
    end
    m_prev_vs = vsync;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    mag = (m_mode != 0) ? mx + mn / 2 : ax + ay;
    if (ax == 0 && ay == 0)      dir = 0;
    else if (256*ay < 106*ax)    dir = 0;
    else if (256*ay > 618*ax)    dir = 2;
    else                         dir = ((gx >= 0) == (gy >= 0)) ? 1 : 3;
    edg = href && (mag >= int'(m_thr));
    if (!href) begin
      mag = 0;
      dir = 0;
    end
    if (edg && clken) m_run++;
    e_vs[o]  = vsync;
    e_hr[o]  = href;
    e_ce[o]  = clken;
    e_mag[o] = mag;
    e_dir[o] = dir;
    e_edg[o] = edg;
  endtask

  task automatic compare(input int c);
    check_eq("vsync", o_vs, e_vs[c]);
    check_eq("href",  o_hr, e_hr[c]);
    check_eq("clken", o_ce, e_ce[c]);
    check_eq("mag",   o_mag, e_mag[c]);
    check_eq("dir",   o_dir, e_dir[c]);
    check_eq("edge",  o_edge, e_edg[c]);
    check_eq("stat_valid", o_stat, e_st[c]);
    if (e_st[c] != 0) m_fec = e_cnt[c];
    check_eq("edge_count", o_fec, m_fec);
    if (o_stat) begin
      pulses++;
      last_fec = o_fec;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc >= NCYC - 8) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NCYC - 8);
      $fatal(1, "cycle budget exceeded");
    end
    if (rst_n) record(cyc);
    #1;
    compare(cyc);
  endtask

  task automatic model_reset();
    for (int j = cyc + 1; j <= cyc + 6; j++) begin
      e_vs[j] = 0; e_hr[j] = 0; e_ce[j] = 0; e_mag[j] = 0;
      e_dir[j] = 0; e_edg[j] = 0; e_st[j] = 0; e_cnt[j] = 0;
    end
    m_thr = 250; m_mode = 0; m_prev_vs = 1'b0; m_run = 0; m_fec = 0;
  endtask

  // kind: 0 flat, 1 vertical step, 2 only P13, 3 only P33, 4 random, 5 any of these
  task automatic set_win(input int kind);
    int k;
    k = (kind == 5) ? int'($urandom_range(0, 4)) : kind;
    for (int i = 0; i < 9; i++) pix[i] = '0;
    case (k)
      0: for (int i = 0; i < 9; i++) pix[i] = 8'd100;
      1: begin
        pix[2] = 8'd255; pix[5] = 8'd255; pix[8] = 8'd255;
        pix[1] = 8'd128; pix[4] = 8'd128; pix[7] = 8'd128;
      end
      2: pix[2] = 8'd200;
      3: pix[8] = 8'd200;
      default: for (int i = 0; i < 9; i++) pix[i] = DATA_W'($urandom_range(0, 255));
    endcase
  endtask

  task automatic line(input int kind, input int width, input bit ce_all);
    for (int i = 0; i < width; i++) begin
      set_win(kind);
      href  = 1'b1;
      clken = ce_all ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick();
    end
    href  = 1'b0;
    clken = 1'b0;
    set_win(4);
    tick();
    tick();
  endtask

  task automatic vs_pulse(input int unsigned thr, input bit mode);
    href     = 1'b0;
    clken    = 1'b0;
    cfg_thr  = MAG_W'(thr);
    cfg_mode = mode;
    vsync    = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    int unsigned p0;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0;
    cfg_thr = 11'd250; cfg_mode = 1'b0;
    for (int i = 0; i < 9; i++) pix[i] = '0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    tick();

    // Directed windows, mode 0 then mode 1
    vs_pulse(250, 1'b0);
    line(0, 4, 1'b1);
    line(1, 4, 1'b1);
    line(2, 4, 1'b1);
    line(3, 4, 1'b1);
    vs_pulse(250, 1'b1);
    line(2, 4, 1'b1);
    line(3, 4, 1'b1);
    line(1, 4, 1'b1);

    // Threshold equal to the step magnitude counts as an edge
    vs_pulse(1020, 1'b0);
    line(1, 3, 1'b1);

    // Frame with exactly 10 edge pixels
    vs_pulse(250, 1'b0);
    line(1, 10, 1'b1);
    line(0, 5, 1'b1);
    p0 = pulses;
    vs_pulse(250, 1'b0);
    check_eq("count10_pulses", pulses - p0, 1);
    check_eq("count10_value", last_fec, 10);

    // Mid-frame threshold change only applies from the next frame
    line(1, 8, 1'b1);
    cfg_thr = 11'd1100;
    line(1, 8, 1'b1);
    vs_pulse(1100, 1'b0);
    check_eq("shadow_old_count", last_fec, 16);
    line(1, 8, 1'b1);
    vs_pulse(1100, 1'b0);
    check_eq("shadow_new_count", last_fec, 0);

    // Reset pulsed mid-line: outputs clear at once, shadows return to defaults
    for (int i = 0; i < 5; i++) begin
      set_win(1); href = 1'b1; clken = 1'b1; tick();
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_href", o_hr, 0);
    check_eq("rst_vsync", o_vs, 0);
    check_eq("rst_mag", o_mag, 0);
    check_eq("rst_edge", o_edge, 0);
    check_eq("rst_stat", o_stat, 0);
    check_eq("rst_count", o_fec, 0);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_win(1); href = 1'b1; clken = 1'b1; tick();
    end
    href = 1'b0; clken = 1'b0;
    tick(); tick();

    // Random frames with random configuration
    for (int f = 0; f < 10; f++) begin
      vs_pulse(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(200, 1200),
               1'($urandom_range(0, 1)));
      for (int l = 0; l < 3; l++) line(5, 12, 1'b0);
      if (f == 4) cfg_thr = MAG_W'($urandom_range(0, 2047));
    end
    vs_pulse(250, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vip_sobel_gradient_dir.md
VIP_SOBEL_GRADIENT_DIR -- requirements
Module: vip_sobel_gradient_dir

Interface
Parameters:
REQ-001 SHALL provide DATA_W, default 8, pixel width; MAG_W = DATA_W+3 derived.
REQ-002 SHALL provide DEF_THRESHOLD, default 250, reset value of the threshold shadow register.
REQ-003 SHALL provide DEF_MODE, default 0, reset value of the magnitude-mode shadow register.
REQ-004 SHALL provide CNT_W, default 20, edge-counter width.

Ports:
REQ-005 SHALL provide clk  in  1  pixel clock, single clock domain.
REQ-006 SHALL provide rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL provide per_frame_vsync / per_frame_href / per_frame_clken  in  1 each  input sync, aligned with the window.
REQ-008 SHALL provide matrix_p11..matrix_p33  in  DATA_W each  3x3 window, unsigned (row 1 top, column 1 left).
REQ-009 SHALL provide cfg_threshold  in  MAG_W  and  cfg_mode  in  1  (0 = L1, 1 = max+min/2).
REQ-010 SHALL provide post_frame_vsync / post_frame_href / post_frame_clken  out  1 each  delayed sync.
REQ-011 SHALL provide post_grad_mag  out  MAG_W,  post_grad_dir  out  2,  post_edge_bit  out  1.
REQ-012 SHALL provide frame_edge_count  out  CNT_W  and  frame_stat_valid  out  1.

Function
REQ-013 SHALL define gx = (P13+2P23+P33) - (P11+2P21+P31) and gy = (P11+2P12+P13) - (P31+2P32+P33), signed, with |gx|, |gy| each <= 4*(2^DATA_W-1) and no overflow.
REQ-014 SHALL be a 4-stage pipeline advancing every clk, regardless of clken:
- S1: row and column weighted sums.
- S2: |gx|, |gy| and sign bits (zero counts as positive).
- S3: magnitude and direction.
- S4: threshold compare and output registers.
REQ-015 SHALL delay vsync, href and clken by exactly 4 clk so that post_* aligns with the data computed from the same window.
REQ-016 SHALL compute the magnitude by mode:
- mode 0: |gx|+|gy|.
- mode 1: max(|gx|,|gy|) + floor(min/2).
- Both fit in MAG_W without saturation.
REQ-017 SHALL set post_grad_dir as follows:
- 0 when 256*|gy| < 106*|gx|.
- 2 when 256*|gy| > 618*|gx|.
- Otherwise 1 if the signs of gx and gy are equal, else 3.
- gx = gy = 0 gives 0.
REQ-018 SHALL set post_edge_bit = 1 iff magnitude >= threshold shadow AND post_frame_href = 1; otherwise 0.
REQ-019 SHALL force post_grad_mag and post_grad_dir to 0 when post_frame_href = 0.
REQ-020 SHALL load cfg_threshold and cfg_mode into the shadow registers only on the clk where the 2-clk-delayed vsync rises, so that every pixel of a frame uses one configuration; mid-frame cfg changes SHALL take effect from the next frame.
REQ-021 SHALL increment a running counter when post_edge_bit = 1 and post_frame_clken = 1, saturating at 2^CNT_W-1.
REQ-022 SHALL, on a rising edge of post_frame_vsync, latch the running counter into frame_edge_count and pulse frame_stat_valid high for exactly 1 clk.
- The running counter clears to 0 in the same clk, or to 1 if a counted pixel coincides with that edge.
REQ-023 SHALL hold frame_edge_count stable between pulses.

Reset
REQ-024 SHALL, while rst_n = 0, clear asynchronously all pipeline registers, sync delays, post_* outputs, the running counter, frame_edge_count and frame_stat_valid to 0, and set the shadows to DEF_THRESHOLD / DEF_MODE.
REQ-025 SHALL, after reset deassertion mid-frame, emit no post_frame_href until a valid input propagates (4 clk); the partial frame produces no frame_stat_valid until the next post_frame_vsync rise.

Verification
REQ-026 SHALL cover a flat window, all pixels = 100, href high: 4 clk later mag = 0, dir = 0, edge = 0.
REQ-027 SHALL cover a vertical step (DATA_W = 8): left column 0, right column 255 -> gx = 1020, gy = 0; mode 0 mag = 1020, dir = 0, edge = 1.
REQ-028 SHALL cover the diagonals:
- Only P13 = 200 -> gx = gy = 200, dir = 1, mag = 400 (mode 0) or 300 (mode 1).
- Only P33 = 200 -> dir = 3.
REQ-029 SHALL cover config shadowing: threshold changed from 250 to 1100 mid-frame -> the step window still gives edge = 1 until the next vsync rise, then edge = 0.
REQ-030 SHALL cover counting: a frame containing 10 edge pixels -> frame_stat_valid is a 1-clk pulse at the next post_frame_vsync rise with frame_edge_count = 10.
REQ-031 SHALL cover reset: rst_n pulsed low mid-line -> all outputs 0 immediately, shadows back to 250 / 0, no stale data emitted after release.
